// File: rtl/cla_carry_pipe.sv
// cla_carry_pipe: two-stage pipelined carry-lookahead resolver.
// Takes XOR-form propagate and generate vectors plus carry-in and produces
// sum and carry-out, with a valid/ready handshake on both sides.
// Stage 1 forms group carry-ins with a group-level lookahead chain.
// Stage 2 ripples inside each group from its registered carry-in.
// Optional feature: define CLA_OVERFLOW_EN to add the registered signed
// overflow output 'ovf'.
module cla_carry_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p_vec,
  input  logic [WIDTH-1:0] g_vec,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NGROUP = WIDTH / BLOCK;

  // Pipeline state
  logic              s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]  p_q, p_d;
  logic [WIDTH-1:0]  g_q, g_d;
  logic [NGROUP-1:0] gcin_q, gcin_d;
  logic              gg_last_q, gg_last_d;
  logic              gp_last_q, gp_last_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
`ifdef CLA_OVERFLOW_EN
  logic              ovf_q, ovf_d;
`endif

  // Handshake and stage-1 / stage-2 combinational results
  logic              s2_ready;
  logic              accept;
  logic              s1_advance;
  logic [NGROUP-1:0] gcin_new;
  logic              gg_last_new;
  logic              gp_last_new;
  logic              grp_g, grp_p, grp_c;
  logic [WIDTH-1:0]  carry_vec;
  logic [WIDTH-1:0]  sum_new;
  logic              cout_new;
  logic              rc;

  // Stage 2 can take new data when empty or when its result leaves this cycle;
  // stage 1 can accept when empty or when it moves into stage 2.
  assign s2_ready   = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_ready;
  assign accept     = in_valid && in_ready;
  assign s1_advance = s1_valid_q && s2_ready;

  // Group generate/propagate reduction and group carry-in chain. Earlier
  // groups' GG/GP are folded into the carry-ins, so only the last group's
  // terms are kept for the final carry-out.
  always_comb begin
    gcin_new    = '0;
    grp_c       = cin;
    grp_g       = 1'b0;
    grp_p       = 1'b0;
    for (int k = 0; k < NGROUP; k++) begin
      gcin_new[k] = grp_c;
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int b = 0; b < BLOCK; b++) begin
        grp_g = g_vec[k*BLOCK+b] | (p_vec[k*BLOCK+b] & grp_g);
        grp_p = grp_p & p_vec[k*BLOCK+b];
      end
      grp_c = grp_g | (grp_p & grp_c);
    end
    gg_last_new = grp_g;
    gp_last_new = grp_p;
  end

  // Stage 1 next state: load on accept, empty out when it drains unrefilled.
  always_comb begin
    s1_valid_d = s1_valid_q;
    p_d        = p_q;
    g_d        = g_q;
    gcin_d     = gcin_q;
    gg_last_d  = gg_last_q;
    gp_last_d  = gp_last_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (accept) begin
      p_d       = p_vec;
      g_d       = g_vec;
      gcin_d    = gcin_new;
      gg_last_d = gg_last_new;
      gp_last_d = gp_last_new;
    end
  end

  // Intra-group ripple from each registered group carry-in.
  always_comb begin
    carry_vec = '0;
    rc        = 1'b0;
    for (int k = 0; k < NGROUP; k++) begin
      rc = gcin_q[k];
      for (int b = 0; b < BLOCK; b++) begin
        carry_vec[k*BLOCK+b] = rc;
        rc = g_q[k*BLOCK+b] | (p_q[k*BLOCK+b] & rc);
      end
    end
    sum_new  = p_q ^ carry_vec;
    cout_new = gg_last_q | (gp_last_q & gcin_q[NGROUP-1]);
  end

  // Stage 2 next state: results hold under backpressure.
  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
`ifdef CLA_OVERFLOW_EN
    ovf_d       = ovf_q;
`endif
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
    end
    if (s1_advance) begin
      sum_d  = sum_new;
      cout_d = cout_new;
`ifdef CLA_OVERFLOW_EN
      ovf_d  = carry_vec[WIDTH-1] ^ cout_new;
`endif
    end
  end

  // Pipeline registers; reset drops everything in flight immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      p_q         <= '0;
      g_q         <= '0;
      gcin_q      <= '0;
      gg_last_q   <= 1'b0;
      gp_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
`ifdef CLA_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      p_q         <= p_d;
      g_q         <= g_d;
      gcin_q      <= gcin_d;
      gg_last_q   <= gg_last_d;
      gp_last_q   <= gp_last_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
`ifdef CLA_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CLA_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_carry_pipe.sv
// tb_cla_carry_pipe: directed self-checking bench for cla_carry_pipe.
`timescale 1ns/1ps
module tb_cla_carry_pipe;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] p_vec;
  logic [31:0] g_vec;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
`ifdef CLA_OVERFLOW_EN
  logic        ovf;
`endif

  typedef struct {
    logic [32:0] res;
    logic        ovf_exp;
    bit          care;
  } exp_t;

  exp_t expq[$];
  int   pop_cycles[$];
  int   cycle_count = 0;
  int   check_count = 0;
  int   fail_count  = 0;
  int   last_accept_cycle = 0;

  cla_carry_pipe #(.WIDTH(32), .BLOCK(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .p_vec    (p_vec),
    .g_vec    (g_vec),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef CLA_OVERFLOW_EN
    ,
    .ovf      (ovf)
`endif
  );

  // Free-running clock and cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cycle_count++;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Reference adder: with XOR-form p/g, a+b = p + 2g.
  function automatic logic [32:0] addModel(input logic [31:0] p, input logic [31:0] g, input logic c);
    return {1'b0, p} + {g, 1'b0} + {32'd0, c};
  endfunction

  function automatic logic ovfModel(input logic [31:0] p, input logic [31:0] g, input logic c);
    logic [32:0] low;
    logic [32:0] full;
    low  = {2'b00, p[30:0]} + {1'b0, g[30:0], 1'b0} + {32'd0, c};
    full = addModel(p, g, c);
    return low[31] ^ full[32];
  endfunction

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // Present one vector and hold it until accepted; queues its expected result.
  task automatic applyStimulus(input logic [31:0] p, input logic [31:0] g, input logic c,
                               input logic [32:0] exp_res, input logic exp_ovf, input bit care);
    bit acc;
    int n;
    exp_t e;
    acc = 0;
    n = 0;
    in_valid = 1'b1;
    p_vec = p;
    g_vec = g;
    cin = c;
    while (!acc && n < 50) begin
      @(negedge clock);
      if (in_ready) begin
        acc = 1;
        e.res = exp_res;
        e.ovf_exp = exp_ovf;
        e.care = care;
        expq.push_back(e);
        last_accept_cycle = cycle_count;
      end
      stepCycle();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 50) begin
      stepCycle();
      n++;
    end
    checkOutput("drain_left", 64'(expq.size()), 64'd0);
  endtask

  // Output monitor: every transfer is matched in order against the queue.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_out", 64'd1, 64'd0);
      end else begin
        e = expq.pop_front();
        pop_cycles.push_back(cycle_count);
        if (e.care) begin
          checkOutput("result", {31'd0, cout, sum}, {31'd0, e.res});
`ifdef CLA_OVERFLOW_EN
          checkOutput("ovf", {63'd0, ovf}, {63'd0, e.ovf_exp});
`endif
        end
      end
    end
  end

  // Hard stop in case something wedges the bench itself.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first_acc;
    logic [31:0] p;
    logic [31:0] g;
    logic        c;

    reset = 1'b1;
    in_valid = 1'b0;
    p_vec = '0;
    g_vec = '0;
    cin = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_sum", {32'd0, sum}, 64'd0);
    checkOutput("rst_cout", {63'd0, cout}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef CLA_OVERFLOW_EN
    checkOutput("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
    stepCycle();
    reset = 1'b0;

    // Full carry ripple and 2-cycle latency
    applyStimulus(32'hFFFF_FFFF, 32'h0, 1'b1, {1'b1, 32'h0000_0000}, 1'b0, 1'b1);
    @(negedge clock);
    checkOutput("t1_not_yet_valid", {63'd0, out_valid}, 64'd0);
    stepCycle();
    @(negedge clock);
    checkOutput("t1_valid_at_2", {63'd0, out_valid}, 64'd1);
    checkOutput("t1_sum", {32'd0, sum}, 64'h0);
    checkOutput("t1_cout", {63'd0, cout}, 64'd1);
    stepCycle();
    waitDrain();

    // Carry-in only, and a generate in the top bit
    applyStimulus(32'h0, 32'h0, 1'b1, {1'b0, 32'h0000_0001}, 1'b0, 1'b1);
    applyStimulus(32'h0, 32'h8000_0000, 1'b0, {1'b1, 32'h0000_0000}, 1'b1, 1'b1);
    waitDrain();

    // Signed overflow into the sign bit
    applyStimulus(32'h7FFF_FFFE, 32'h0000_0001, 1'b0, {1'b0, 32'h8000_0000}, 1'b1, 1'b1);
    waitDrain();

    // Ten back-to-back vectors at full throughput
    pop_cycles.delete();
    first_acc = 0;
    for (int i = 0; i < 10; i++) begin
      p = 32'h1234_5678 + (32'(i) * 32'h0101_0101);
      g = ~p & 32'h00FF_0FF0;
      c = i[0];
      applyStimulus(p, g, c, addModel(p, g, c), ovfModel(p, g, c), 1'b1);
      if (i == 0) first_acc = last_accept_cycle;
    end
    checkOutput("t4_accept_span", 64'(last_accept_cycle - first_acc), 64'd9);
    waitDrain();
    checkOutput("t4_out_count", 64'(pop_cycles.size()), 64'd10);
    if (pop_cycles.size() == 10)
      checkOutput("t4_out_span", 64'(pop_cycles[9] - pop_cycles[0]), 64'd9);

    // Backpressure: both stages fill, output holds, then drains in order
    out_ready = 1'b0;
    applyStimulus(32'h0000_0001, 32'h0, 1'b0, {1'b0, 32'h0000_0001}, 1'b0, 1'b1);
    applyStimulus(32'h0, 32'h0000_0002, 1'b1, {1'b0, 32'h0000_0005}, 1'b0, 1'b1);
    in_valid = 1'b1;
    p_vec = 32'hFFFF_0000;
    g_vec = 32'h0000_FFFF;
    cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("t5_in_ready_low", {63'd0, in_ready}, 64'd0);
      checkOutput("t5_hold_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("t5_hold_sum", {32'd0, sum}, 64'h1);
      stepCycle();
    end
    out_ready = 1'b1;
    applyStimulus(32'hFFFF_0000, 32'h0000_FFFF, 1'b0, {1'b1, 32'h0000_FFFE}, 1'b0, 1'b1);
    waitDrain();

    // Illegal p&g must not stall the following vector
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h0, 1'b0, 1'b0);
    applyStimulus(32'h0000_0002, 32'h0000_0001, 1'b0, {1'b0, 32'h0000_0004}, 1'b0, 1'b1);
    waitDrain();

    // Reset with both stages full drops everything
    out_ready = 1'b0;
    applyStimulus(32'h0000_00F0, 32'h0, 1'b0, {1'b0, 32'h0000_00F0}, 1'b0, 1'b1);
    applyStimulus(32'h0000_0F00, 32'h0, 1'b0, {1'b0, 32'h0000_0F00}, 1'b0, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    expq.delete();
    checkOutput("t6_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("t6_sum", {32'd0, sum}, 64'h0);
    checkOutput("t6_cout", {63'd0, cout}, 64'd0);
    stepCycle();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("t6_no_stale", {63'd0, out_valid}, 64'd0);
      stepCycle();
    end
    applyStimulus(32'h0000_0005, 32'h0, 1'b0, {1'b0, 32'h0000_0005}, 1'b0, 1'b1);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
